ps2_zx_keyboard: RTL and testbench
==================================

// Module: ps2_zx_keyboard
// PURPOSE
// PS/2 (scancode set 2) keyboard receiver and ZX Spectrum 8x5 key-matrix emulator; upstream of the port decoder.
// Receives device-to-host frames, tracks make/break state, keeps a pressed-key matrix, and returns the active-low
// 5-bit column value for the half-rows selected by the CPU address high byte. Also detects Ctrl+Alt+Del.
// PARAMETERS
// FILTER_LEN   8      consecutive equal samples (clk28) before a synchronised PS/2 line level is accepted
// TIMEOUT      28000  clk28 cycles (~1 ms) without a PS/2 clock fall mid-frame -> frame aborted
// PORTS
// clk28      in   1  system clock, 28 MHz
// rst_n      in   1  reset, synchronous, active-low
// ps2_clk    in   1  PS/2 clock pin, asynchronous, idle high
// ps2_dat    in   1  PS/2 data pin, asynchronous, idle high
// addr_hi    in   8  CPU address A15..A8; bit r low selects matrix half-row r
// kd         out  5  column data, active-low (1 = no key), bit0 = outermost key
// reset_req  out  1  one-cycle pulse on Ctrl+Alt+Del make
// frame_err  out  1  one-cycle pulse when a frame is discarded (parity/start/stop/timeout)
// BEHAVIOUR
// - Reset: kd=5'b11111, reset_req=0, frame_err=0, FSM=IDLE, matrix/composite/modifier/prefix state all cleared.
//   Sync reset mid-frame aborts the frame; no partial byte is ever decoded.
// - Input: 2-FF sync per line, then filter: output level changes only after FILTER_LEN identical samples.
//   Data sampled on a filtered ps2_clk falling edge only.
// - Frame FSM: IDLE -(fall, dat=0)-> DATA (8 bits, LSB first) -> PARITY -> STOP -> IDLE.
//   IDLE fall with dat=1: stay IDLE, pulse frame_err. Odd parity wrong or stop=0: discard, pulse frame_err.
//   Counter reloads on each fall; reaching TIMEOUT outside IDLE -> IDLE + frame_err. Valid byte strobed on STOP fall.
// - Decoder per byte: F0 -> set brk; E0 -> set ext; E1 -> ignore next 7 bytes (Pause).
//   Other byte: key event (make if !brk), then brk=ext=0. E0 12 / E0 59 (fake shifts) ignored. Unmapped codes ignored.
// - Matrix rows, bits 0..4: r0 CS Z X C V | r1 A S D F G | r2 Q W E R T | r3 1 2 3 4 5 |
//   r4 0 9 8 7 6 | r5 P O I U Y | r6 ENT L K J H | r7 SP SS M N B.
// - Direct keys: standard set-2 codes (e.g. 1C=A, 1A=Z, 16=1, 45=0, 5A=Enter, 29=Space),
//   12=CS (left shift), 59=SS (right shift).
// - Composite keys, each with its own state bit, adding CS plus the listed key:
//   66 Bksp=0; E0 6B Left=5; E0 72 Down=6; E0 75 Up=7; E0 74 Right=8.
// - Pressed(r,c) = direct(r,c) | any composite mapping to (r,c). Releasing a composite never clears a CS held by
//   Left Shift, and the reverse also holds.
// - Modifiers: ctrl = 14 or E0 14; alt = 11 or E0 11. E0 71 (Del) make with ctrl&alt -> reset_req for 1 cycle.
//   Typematic repeats do not re-pulse until Del is released.
// - Output: kd[c] = ~OR over r with addr_hi[r]==0 of Pressed(r,c). Registered, 1 clk28 latency from addr_hi or
//   matrix change. addr_hi=FF -> 11111; addr_hi=00 -> AND of all rows.
// - Repeated make of an already-pressed key: no change. Break of a released key: no change.
// TESTING
// - Send 1C valid frame, addr_hi=FD -> kd=11110 after 1 clk; then F0 1C -> kd=11111.
// - Hold 12 (LShift) + E0 6B; addr_hi=FE -> kd=11110; addr_hi=F7 -> kd=01111.
//   Release E0 6B -> FE still 11110; release 12 -> FE 11111.
// - Frame with bad parity for 1C -> frame_err pulse, matrix unchanged. Stop clock after 4 bits ->
//   frame_err after TIMEOUT cycles, next good frame decodes.
// - 14, 11, E0 71 -> single reset_req pulse; repeated E0 71 without break -> no second pulse.
// - Assert rst_n=0 mid-frame with keys held -> kd=11111 next cycle, FSM IDLE, remaining bits not decoded.
// - Glitch ps2_clk low for FILTER_LEN-1 cycles -> no bit shifted; E1 14 77 E1 F0 14 F0 77 -> matrix unchanged.

Source files
------------

// File: rtl/ps2_zx_keyboard.sv
// PS/2 set-2 keyboard receiver driving an emulated ZX Spectrum 8x5 key matrix.
// Ports:
//   clk28      system clock (28 MHz)
//   rst_n      synchronous active-low reset
//   ps2_clk    PS/2 clock pin (async, idle high)
//   ps2_dat    PS/2 data pin (async, idle high)
//   addr_hi    CPU A15..A8; a low bit r selects half-row r
//   kd         active-low column data for the selected half-rows (registered)
//   reset_req  one-cycle pulse on Ctrl+Alt+Del make
//   frame_err  one-cycle pulse when a frame is discarded
module ps2_zx_keyboard #(
  parameter int unsigned FILTER_LEN = 8,
  parameter int unsigned TIMEOUT    = 28000
) (
  input  logic       clk28,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  input  logic [7:0] addr_hi,
  output logic [4:0] kd,
  output logic       reset_req,
  output logic       frame_err
);

  localparam int unsigned FW = $clog2(FILTER_LEN + 1);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

  // ---------------- input synchronisers and glitch filters ----------------
  logic [1:0]         clk_sync, dat_sync;
  logic [1:0]         raw, filt;        // index 0 = clock, 1 = data
  logic [1:0][FW-1:0] fcnt;
  logic               clk_prev;
  logic               fall_c;
  logic               dat_f;

  assign raw    = {dat_sync[1], clk_sync[1]};
  assign dat_f  = filt[1];
  assign fall_c = clk_prev & ~filt[0];

  always_ff @(posedge clk28) begin
    if (!rst_n) begin
      clk_sync <= 2'b11;
      dat_sync <= 2'b11;
      filt     <= 2'b11;
      fcnt     <= '0;
      clk_prev <= 1'b1;
    end else begin
      clk_sync <= {clk_sync[0], ps2_clk};
      dat_sync <= {dat_sync[0], ps2_dat};
      clk_prev <= filt[0];
      // Level flips on the FILTER_LEN-th consecutive differing sample.
      for (int i = 0; i < 2; i++) begin
        if (raw[i] == filt[i]) begin
          fcnt[i] <= '0;
        end else if (fcnt[i] == FW'(FILTER_LEN - 1)) begin
          filt[i] <= raw[i];
          fcnt[i] <= '0;
        end else begin
          fcnt[i] <= fcnt[i] + 1'b1;
        end
      end
    end
  end

  // ---------------- frame receiver ----------------
  state_t        state_q, state_d;
  logic [2:0]    bit_cnt_q;
  logic [7:0]    shift_q;
  logic          par_ok_q;
  logic [TW-1:0] tmo_q;
  logic          err_c, byte_c, tmo_hit_c;
  logic          byte_vld_q;
  logic [7:0]    byte_q;

  always_ff @(posedge clk28) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next state; parity result is held until the stop bit so a bad frame
  // produces exactly one error pulse.
  always_comb begin
    state_d   = state_q;
    err_c     = 1'b0;
    byte_c    = 1'b0;
    tmo_hit_c = (state_q != S_IDLE) && (tmo_q == TW'(TIMEOUT - 1));
    if (fall_c) begin
      case (state_q)
        S_IDLE:   if (!dat_f) state_d = S_DATA; else err_c = 1'b1;
        S_DATA:   if (bit_cnt_q == 3'd7) state_d = S_PARITY;
        S_PARITY: state_d = S_STOP;
        S_STOP: begin
          state_d = S_IDLE;
          if (dat_f && par_ok_q) byte_c = 1'b1;
          else                   err_c  = 1'b1;
        end
        default:  state_d = S_IDLE;
      endcase
    end else if (tmo_hit_c) begin
      state_d = S_IDLE;
      err_c   = 1'b1;
    end
  end

  always_ff @(posedge clk28) begin
    if (!rst_n) begin
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      par_ok_q   <= 1'b0;
      tmo_q      <= '0;
      frame_err  <= 1'b0;
      byte_vld_q <= 1'b0;
      byte_q     <= '0;
    end else begin
      frame_err  <= err_c;
      byte_vld_q <= byte_c;
      if (byte_c) byte_q <= shift_q;
      if (fall_c || state_q == S_IDLE) tmo_q <= '0;
      else                             tmo_q <= tmo_q + 1'b1;
      if (fall_c) begin
        case (state_q)
          S_IDLE:   bit_cnt_q <= '0;
          S_DATA: begin
            shift_q   <= {dat_f, shift_q[7:1]};
            bit_cnt_q <= bit_cnt_q + 1'b1;
          end
          S_PARITY: par_ok_q <= (^shift_q) ^ dat_f;
          default:  ;
        endcase
      end
    end
  end

  // ---------------- scancode decoder ----------------
  logic            brk_q, ext_q;
  logic [2:0]      skip_q;
  logic [7:0][4:0] direct_q;
  logic [4:0]      comp_q;   // Bksp, Left, Down, Up, Right
  logic            ctrl_l_q, ctrl_r_q, alt_l_q, alt_r_q, del_q;
  logic [6:0]      dmap_c;   // {hit, row, col}
  logic            comp_hit_c;
  logic [2:0]      comp_idx_c;
  logic            make_c;

  function automatic logic [6:0] dk(input int unsigned r, input int unsigned c);
    return {1'b1, 3'(r), 3'(c)};
  endfunction

  assign make_c = ~brk_q;

  // Unextended codes that map straight onto one matrix position.
  always_comb begin
    dmap_c = '0;
    if (!ext_q) begin
      case (byte_q)
        8'h12: dmap_c = dk(0, 0);  8'h1A: dmap_c = dk(0, 1);  8'h22: dmap_c = dk(0, 2);
        8'h21: dmap_c = dk(0, 3);  8'h2A: dmap_c = dk(0, 4);
        8'h1C: dmap_c = dk(1, 0);  8'h1B: dmap_c = dk(1, 1);  8'h23: dmap_c = dk(1, 2);
        8'h2B: dmap_c = dk(1, 3);  8'h34: dmap_c = dk(1, 4);
        8'h15: dmap_c = dk(2, 0);  8'h1D: dmap_c = dk(2, 1);  8'h24: dmap_c = dk(2, 2);
        8'h2D: dmap_c = dk(2, 3);  8'h2C: dmap_c = dk(2, 4);
        8'h16: dmap_c = dk(3, 0);  8'h1E: dmap_c = dk(3, 1);  8'h26: dmap_c = dk(3, 2);
        8'h25: dmap_c = dk(3, 3);  8'h2E: dmap_c = dk(3, 4);
        8'h45: dmap_c = dk(4, 0);  8'h46: dmap_c = dk(4, 1);  8'h3E: dmap_c = dk(4, 2);
        8'h3D: dmap_c = dk(4, 3);  8'h36: dmap_c = dk(4, 4);
        8'h4D: dmap_c = dk(5, 0);  8'h44: dmap_c = dk(5, 1);  8'h43: dmap_c = dk(5, 2);
        8'h3C: dmap_c = dk(5, 3);  8'h35: dmap_c = dk(5, 4);
        8'h5A: dmap_c = dk(6, 0);  8'h4B: dmap_c = dk(6, 1);  8'h42: dmap_c = dk(6, 2);
        8'h3B: dmap_c = dk(6, 3);  8'h33: dmap_c = dk(6, 4);
        8'h29: dmap_c = dk(7, 0);  8'h59: dmap_c = dk(7, 1);  8'h3A: dmap_c = dk(7, 2);
        8'h31: dmap_c = dk(7, 3);  8'h32: dmap_c = dk(7, 4);
        default: dmap_c = '0;
      endcase
    end
  end

  // Keys that emulate CS plus another key.
  always_comb begin
    comp_hit_c = 1'b1;
    comp_idx_c = '0;
    case ({ext_q, byte_q})
      9'h066:  comp_idx_c = 3'd0;
      9'h16B:  comp_idx_c = 3'd1;
      9'h172:  comp_idx_c = 3'd2;
      9'h175:  comp_idx_c = 3'd3;
      9'h174:  comp_idx_c = 3'd4;
      default: comp_hit_c = 1'b0;
    endcase
  end

  always_ff @(posedge clk28) begin
    if (!rst_n) begin
      brk_q     <= 1'b0;
      ext_q     <= 1'b0;
      skip_q    <= '0;
      direct_q  <= '0;
      comp_q    <= '0;
      ctrl_l_q  <= 1'b0;
      ctrl_r_q  <= 1'b0;
      alt_l_q   <= 1'b0;
      alt_r_q   <= 1'b0;
      del_q     <= 1'b0;
      reset_req <= 1'b0;
    end else begin
      reset_req <= 1'b0;
      if (byte_vld_q) begin
        if (skip_q != 3'd0) begin
          skip_q <= skip_q - 1'b1;          // swallowing the Pause sequence
        end else if (byte_q == 8'hF0) begin
          brk_q <= 1'b1;
        end else if (byte_q == 8'hE0) begin
          ext_q <= 1'b1;
        end else if (byte_q == 8'hE1) begin
          skip_q <= 3'd7;
          brk_q  <= 1'b0;
          ext_q  <= 1'b0;
        end else begin
          brk_q <= 1'b0;
          ext_q <= 1'b0;
          if (dmap_c[6]) direct_q[dmap_c[5:3]][dmap_c[2:0]] <= make_c;
          if (comp_hit_c) comp_q[comp_idx_c] <= make_c;
          case ({ext_q, byte_q})
            9'h014: ctrl_l_q <= make_c;
            9'h114: ctrl_r_q <= make_c;
            9'h011: alt_l_q  <= make_c;
            9'h111: alt_r_q  <= make_c;
            9'h171: begin
              del_q <= make_c;
              // Only the first make fires; typematic repeats are ignored.
              if (make_c && !del_q && (ctrl_l_q || ctrl_r_q) && (alt_l_q || alt_r_q))
                reset_req <= 1'b1;
            end
            default: ;
          endcase
        end
      end
    end
  end

  // ---------------- matrix readout ----------------
  logic [7:0][4:0] pressed_c;
  logic [4:0]      col_c;

  always_comb begin
    pressed_c       = direct_q;
    pressed_c[0][0] = direct_q[0][0] | (|comp_q);
    pressed_c[4][0] = direct_q[4][0] | comp_q[0];
    pressed_c[3][4] = direct_q[3][4] | comp_q[1];
    pressed_c[4][4] = direct_q[4][4] | comp_q[2];
    pressed_c[4][3] = direct_q[4][3] | comp_q[3];
    pressed_c[4][2] = direct_q[4][2] | comp_q[4];
  end

  always_comb begin
    col_c = '0;
    for (int r = 0; r < 8; r++) begin
      if (!addr_hi[r]) col_c = col_c | pressed_c[r];
    end
  end

  always_ff @(posedge clk28) begin
    if (!rst_n) kd <= 5'b11111;
    else        kd <= ~col_c;
  end

endmodule

// File: tb/tb_ps2_zx_keyboard.sv
// Bench for ps2_zx_keyboard: directed scenarios plus random key traffic,
// checked against a key-level model (set of held keys -> matrix positions).
module tb_ps2_zx_keyboard;

  localparam int unsigned FILT = 8;
  localparam int unsigned TMO  = 2000;

  logic       clk28 = 1'b0;
  logic       rst_n = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_dat = 1'b1;
  logic [7:0] addr_hi = 8'hFF;
  logic [4:0] kd;
  logic       reset_req, frame_err;

  int checks = 0;
  int errors = 0;
  int fe_seen = 0, rr_seen = 0;
  int exp_fe = 0, exp_rr = 0;

  // Model state: held keys indexed by {ext, code}, plus byte-stream prefix state.
  bit held [512];
  bit m_brk, m_ext;
  int m_skip;

  logic [8:0] pool [22] = '{9'h012, 9'h059, 9'h01C, 9'h01A, 9'h016, 9'h045, 9'h05A,
                            9'h029, 9'h02B, 9'h03A, 9'h066, 9'h16B, 9'h172, 9'h175,
                            9'h174, 9'h014, 9'h011, 9'h114, 9'h111, 9'h171, 9'h112,
                            9'h00E};

  ps2_zx_keyboard #(.FILTER_LEN(FILT), .TIMEOUT(TMO)) dut (
    .clk28(clk28), .rst_n(rst_n), .ps2_clk(ps2_clk), .ps2_dat(ps2_dat),
    .addr_hi(addr_hi), .kd(kd), .reset_req(reset_req), .frame_err(frame_err)
  );

  always #5 clk28 = ~clk28;

  always @(negedge clk28) begin
    if (frame_err) fe_seen++;
    if (reset_req) rr_seen++;
  end

  function automatic logic [39:0] pm(input int r, input int c);
    logic [39:0] one;
    one = 40'd1;
    return one << (r * 5 + c);
  endfunction

  // ZX positions each PC key produces (composites add Caps Shift at r0c0).
  function automatic logic [39:0] key_mask(input int id);
    case (id)
      'h012: return pm(0, 0);
      'h059: return pm(7, 1);
      'h01C: return pm(1, 0);
      'h01A: return pm(0, 1);
      'h016: return pm(3, 0);
      'h045: return pm(4, 0);
      'h05A: return pm(6, 0);
      'h029: return pm(7, 0);
      'h02B: return pm(1, 3);
      'h03A: return pm(7, 2);
      'h066: return pm(0, 0) | pm(4, 0);
      'h16B: return pm(0, 0) | pm(3, 4);
      'h172: return pm(0, 0) | pm(4, 4);
      'h175: return pm(0, 0) | pm(4, 3);
      'h174: return pm(0, 0) | pm(4, 2);
      default: return 40'd0;
    endcase
  endfunction

  function automatic logic [4:0] model_kd(input logic [7:0] a);
    logic [39:0] p;
    logic [4:0]  k;
    p = '0;
    for (int id = 0; id < 512; id++) if (held[id]) p |= key_mask(id);
    for (int c = 0; c < 5; c++) begin
      k[c] = 1'b1;
      for (int r = 0; r < 8; r++) if (!a[r] && p[r * 5 + c]) k[c] = 1'b0;
    end
    return k;
  endfunction

  task automatic model_byte(input logic [7:0] b);
    int id;
    bit mk;
    if (m_skip > 0) m_skip--;
    else if (b == 8'hF0) m_brk = 1;
    else if (b == 8'hE0) m_ext = 1;
    else if (b == 8'hE1) begin m_skip = 7; m_brk = 0; m_ext = 0; end
    else begin
      id = {23'd0, m_ext, b};
      mk = !m_brk;
      if (id == 'h171 && mk && !held['h171] && (held['h014] || held['h114])
          && (held['h011] || held['h111])) exp_rr++;
      held[id] = mk;
      m_brk = 0;
      m_ext = 0;
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 512; i++) held[i] = 0;
    m_brk = 0; m_ext = 0; m_skip = 0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk28);
  endtask

  task automatic ps2_bit(input logic b);
    ps2_dat = b;
    idle(10);
    ps2_clk = 1'b0;
    idle(15);
    ps2_clk = 1'b1;
    idle(10);
  endtask

  // Drives nbits of a frame (start, data LSB first, odd parity, stop).
  task automatic send_frame(input logic [7:0] b, input bit bad_par, input int nbits,
                            input bit glitch);
    logic [10:0] f;
    f = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_bit(f[i]);
      if (glitch && i == 3) begin
        ps2_clk = 1'b0;
        idle(FILT - 1);
        ps2_clk = 1'b1;
        idle(5);
      end
    end
    ps2_dat = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_frame(b, 1'b0, 11, 1'b0);
    model_byte(b);
    idle(20);
  endtask

  task automatic key(input int id, input bit mk);
    if (id >= 'h100) send_byte(8'hE0);
    if (!mk) send_byte(8'hF0);
    send_byte(8'(id));
  endtask

  task automatic chk_kd(input string tag, input logic [7:0] a);
    addr_hi = a;
    @(negedge clk28);
    chk(tag, {27'd0, kd}, {27'd0, model_kd(a)});
  endtask

  initial begin
    int fe0;
    int id;
    model_reset();

    // Reset state
    idle(4);
    chk("rst_kd", {27'd0, kd}, 32'h1F);
    chk("rst_rr", {31'd0, reset_req}, 32'd0);
    chk("rst_fe", {31'd0, frame_err}, 32'd0);
    rst_n = 1'b1;
    idle(20);

    // A press: one-cycle latency from addr_hi
    key('h01C, 1);
    addr_hi = 8'hFF;
    @(negedge clk28);
    addr_hi = 8'hFD;
    chk("lat_before", {27'd0, kd}, 32'h1F);
    @(negedge clk28);
    chk("a_make", {27'd0, kd}, 32'h1E);
    key('h01C, 0);
    chk_kd("a_break", 8'hFD);
    chk("a_break_const", {27'd0, kd}, 32'h1F);

    // LShift + Left share Caps Shift
    key('h012, 1);
    key('h16B, 1);
    chk_kd("sh_left_fe", 8'hFE);
    chk("sh_left_fe_c", {27'd0, kd}, 32'h1E);
    chk_kd("sh_left_f7", 8'hF7);
    chk("sh_left_f7_c", {27'd0, kd}, 32'h0F);
    key('h16B, 0);
    chk_kd("left_rel_fe", 8'hFE);
    chk("left_rel_fe_c", {27'd0, kd}, 32'h1E);
    key('h012, 0);
    chk_kd("sh_rel_fe", 8'hFE);
    chk("sh_rel_fe_c", {27'd0, kd}, 32'h1F);

    // Bad parity
    send_frame(8'h1C, 1'b1, 11, 1'b0);
    exp_fe++;
    idle(20);
    chk("par_fe", fe_seen, exp_fe);
    chk_kd("par_kd", 8'hFD);

    // Timeout after 4 bits, then recovery
    send_frame(8'h1C, 1'b0, 4, 1'b0);
    fe0 = fe_seen;
    idle(TMO - 100);
    chk("tmo_early", fe_seen, fe0);
    for (int i = 0; i < 400 && fe_seen == fe0; i++) @(negedge clk28);
    exp_fe++;
    chk("tmo_fe", fe_seen, exp_fe);
    key('h01C, 1);
    chk_kd("tmo_recover", 8'hFD);
    key('h01C, 0);

    // Ctrl+Alt+Del
    key('h014, 1);
    key('h011, 1);
    key('h171, 1);
    idle(5);
    chk("cad_pulse", rr_seen, 1);
    key('h171, 1);
    idle(5);
    chk("cad_repeat", rr_seen, exp_rr);
    key('h171, 0);
    key('h011, 0);
    key('h014, 0);

    // Glitch mid-frame and in idle
    send_frame(8'h45, 1'b0, 11, 1'b1);
    model_byte(8'h45);
    idle(20);
    chk_kd("glitch_kd", 8'hEF);
    ps2_clk = 1'b0;
    idle(FILT - 1);
    ps2_clk = 1'b1;
    idle(30);
    chk("glitch_fe", fe_seen, exp_fe);

    // Pause sequence is swallowed
    foreach (pool[i]) begin end
    send_byte(8'hE1); send_byte(8'h14); send_byte(8'h77);
    send_byte(8'hE1); send_byte(8'hF0); send_byte(8'h14);
    send_byte(8'hF0); send_byte(8'h77);
    chk_kd("pause_kd", 8'h00);
    key('h011, 1);
    key('h171, 1);
    idle(5);
    chk("pause_no_ctrl", rr_seen, exp_rr);
    key('h171, 0);
    key('h011, 0);

    // Random key traffic
    for (int n = 0; n < 30; n++) begin
      id = int'(pool[$urandom_range(21, 0)]);
      key(id, 1'($urandom_range(1, 0)));
      chk_kd("rnd_kd", 8'($urandom));
    end
    chk("rnd_rr", rr_seen, exp_rr);
    chk("rnd_fe", fe_seen, exp_fe);

    // Sync reset mid-frame with keys held
    key('h01C, 1);
    key('h016, 1);
    addr_hi = 8'h00;
    send_frame(8'h1A, 1'b0, 4, 1'b0);
    rst_n = 1'b0;
    @(negedge clk28);
    chk("mid_rst_kd", {27'd0, kd}, 32'h1F);
    rst_n = 1'b1;
    model_reset();
    ps2_clk = 1'b1;
    ps2_dat = 1'b1;
    idle(TMO + 200);
    chk("mid_rst_idle", fe_seen, exp_fe);
    chk_kd("mid_rst_matrix", 8'h00);
    key('h01A, 1);
    chk_kd("post_rst_z", 8'hFE);
    chk("post_rst_z_c", {27'd0, kd}, 32'h1D);
    chk("final_rr", rr_seen, exp_rr);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
